// File: rtl/dmem_if.sv
// MEM-stage data-RAM bus: the core drives address/data/controls, the responder returns load data.
// A request is presented for exactly one cycle and is always accepted; there is no ready,
// and load data is combinational in the same cycle (ram_re/ram_we act as the valid strobes).
interface dmem_if;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [2:0]  ram_func3;
    logic [31:0] ram_rdata;

    modport master (
        output ram_addr, ram_wdata, ram_we, ram_re, ram_func3,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr, ram_wdata, ram_we, ram_re, ram_func3,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with byte-lane stores, same-cycle formatted loads,
// a sticky first-error capture and wrapping load/store counters.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    input  logic        err_clr,
    output logic        mem_err,
    output logic [31:0] err_addr,
    output logic [15:0] ld_count,
    output logic [15:0] st_count
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          func_ok;
    logic          aligned;
    logic          access;
    logic          legal;
    logic          st_fire;
    logic          ld_fire;
    logic          err_fire;
    logic [3:0]    strobe;
    logic [31:0]   wdata_sh;
    logic [31:0]   rd_word;
    logic [31:0]   rd_sh;
    logic [31:0]   rdata_fmt;

    logic          mem_err_q, mem_err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic [15:0]   ld_cnt_q, ld_cnt_d;
    logic [15:0]   st_cnt_q, st_cnt_d;

    // BASE_ADDR is aligned to the array size, so an address below the base wraps
    // to a large offset and fails the same upper-bits test as one above the top.
    assign offset   = bus.ram_addr - BASE_ADDR;
    assign lane     = offset[1:0];
    assign word_idx = offset[AW+1:2];
    assign in_range = (offset[31:AW+2] == '0);

    always_comb begin
        func_ok = 1'b0;
        if (bus.ram_we) begin
            func_ok = (bus.ram_func3 == 3'b000) || (bus.ram_func3 == 3'b001) ||
                      (bus.ram_func3 == 3'b010);
        end else begin
            func_ok = (bus.ram_func3 == 3'b000) || (bus.ram_func3 == 3'b001) ||
                      (bus.ram_func3 == 3'b010) || (bus.ram_func3 == 3'b100) ||
                      (bus.ram_func3 == 3'b101);
        end
    end

    always_comb begin
        aligned = 1'b0;
        case (bus.ram_func3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign access   = bus.ram_we | bus.ram_re;
    assign legal    = in_range & func_ok & aligned;
    assign st_fire  = ~rst & bus.ram_we & legal;
    assign ld_fire  = ~rst & bus.ram_re & ~bus.ram_we & legal;
    assign err_fire = ~rst & access & ~legal;

    always_comb begin
        strobe = 4'b0000;
        case (bus.ram_func3[1:0])
            2'b00:   strobe = 4'b0001 << lane;
            2'b01:   strobe = 4'b0011 << lane;
            2'b10:   strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
    end

    assign wdata_sh = bus.ram_wdata << {lane, 3'b000};

    // RAM contents survive reset; only the write enable is gated by it.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (strobe[k]) mem_q[word_idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    // Pre-write word, so a combined load/store shows the old contents.
    assign rd_word = mem_q[word_idx];
    assign rd_sh   = rd_word >> {lane, 3'b000};

    always_comb begin
        rdata_fmt = 32'h0;
        case (bus.ram_func3)
            3'b000:  rdata_fmt = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b100:  rdata_fmt = {24'h0, rd_sh[7:0]};
            3'b001:  rdata_fmt = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b101:  rdata_fmt = {16'h0, rd_sh[15:0]};
            3'b010:  rdata_fmt = rd_sh;
            default: rdata_fmt = 32'h0;
        endcase
    end

    assign bus.ram_rdata = (~rst & access & legal) ? rdata_fmt : 32'h0;

    always_comb begin
        mem_err_d  = mem_err_q;
        err_addr_d = err_addr_q;
        ld_cnt_d   = ld_cnt_q;
        st_cnt_d   = st_cnt_q;
        // A fresh error outranks a clear in the same cycle and re-captures the address.
        if (err_fire && (!mem_err_q || err_clr)) begin
            mem_err_d  = 1'b1;
            err_addr_d = bus.ram_addr;
        end else if (err_clr) begin
            mem_err_d = 1'b0;
        end
        if (ld_fire) ld_cnt_d = ld_cnt_q + 16'd1;
        if (st_fire) st_cnt_d = st_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_q  <= 1'b0;
            err_addr_q <= 32'h0;
            ld_cnt_q   <= 16'h0;
            st_cnt_q   <= 16'h0;
        end else begin
            mem_err_q  <= mem_err_d;
            err_addr_q <= err_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    assign mem_err  = mem_err_q;
    assign err_addr = err_addr_q;
    assign ld_count = ld_cnt_q;
    assign st_count = st_cnt_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized byte-level reference model.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        err_clr;
    logic        mem_err;
    logic [31:0] err_addr;
    logic [15:0] ld_count;
    logic [15:0] st_count;

    dmem_if bus ();

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_clr  (err_clr),
        .mem_err  (mem_err),
        .err_addr (err_addr),
        .ld_count (ld_count),
        .st_count (st_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;
    logic [15:0] ld_exp = 16'h0;
    logic [15:0] st_exp = 16'h0;
    logic [7:0]  model_b [64];

    // driver: present one request just after an edge, return at the following falling edge
    task automatic drive(input logic we, input logic re, input logic clr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.ram_we    = we;
        bus.ram_re    = re;
        err_clr       = clr;
        bus.ram_func3 = f3;
        bus.ram_addr  = a;
        bus.ram_wdata = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.ram_we = 1'b0;
        bus.ram_re = 1'b0;
        err_clr    = 1'b0;
        bus.ram_func3 = 3'b000;
        bus.ram_addr  = 32'h0;
        bus.ram_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", got, exp); end
        idle();
        checks++;
        if ({mem_err, err_addr, ld_count, st_count} !== 65'h0) begin
            errors++;
            $display("FAIL reset_regs got err=%b addr=%h ld=%h st=%h exp all 0", mem_err, err_addr, ld_count, st_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF); st_exp++;
        exp_q.push_back(32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0); ld_exp++;
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL lw_word got=%h exp=%h", got, exp); end
        idle();
        checks++;
        if (ld_count !== 16'd1 || st_count !== 16'd1) begin
            errors++; $display("FAIL word_counts got ld=%0d st=%0d exp ld=1 st=1", ld_count, st_count);
        end
    endtask

    task automatic test_byte_half();
        logic [2:0]  f3_t [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] a_t  [6] = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        logic [31:0] e_t  [6] = '{32'hDEADAAEF, 32'hFFFFFFAA, 32'h000000AA,
                                  32'hFFFF8001, 32'h00008001, 32'h8001AAEF};
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h11, 32'h123456AA); st_exp++;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin drive(1'b1, 1'b0, 1'b0, 3'b001, 32'h12, 32'h55558001); st_exp++; end
            exp_q.push_back(e_t[i]);
            drive(1'b0, 1'b1, 1'b0, f3_t[i], a_t[i], 32'h0); ld_exp++;
            got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL byte_half[%0d] got=%h exp=%h", i, got, exp); end
        end
        idle();
        checks++;
        if (ld_count !== ld_exp || st_count !== st_exp) begin
            errors++; $display("FAIL bh_counts got ld=%0d st=%0d exp ld=%0d st=%0d", ld_count, st_count, ld_exp, st_exp);
        end
    endtask

    task automatic test_errors();
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h11111111); st_exp++;
        idle();
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL err_idle got=%b exp=0", mem_err); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h13, 32'h0);
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL misalign_rdata got=%h exp=%h", got, exp); end
        idle();
        checks++;
        if (mem_err !== 1'b1 || err_addr !== 32'h13) begin
            errors++; $display("FAIL misalign_err got err=%b addr=%h exp err=1 addr=00000013", mem_err, err_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h4000, 32'h55555555);
        drive(1'b1, 1'b0, 1'b0, 3'b100, 32'h0, 32'h66666666);
        idle();
        checks++;
        if (err_addr !== 32'h13) begin errors++; $display("FAIL first_err_wins got=%h exp=00000013", err_addr); end
        exp_q.push_back(32'h11111111);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0); ld_exp++;
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL no_bad_write got=%h exp=%h", got, exp); end
        drive(1'b0, 1'b1, 1'b1, 3'b001, 32'h21, 32'h0);
        idle();
        checks++;
        if (mem_err !== 1'b1 || err_addr !== 32'h21) begin
            errors++; $display("FAIL clr_with_err got err=%b addr=%h exp err=1 addr=00000021", mem_err, err_addr);
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0);
        idle();
        checks++;
        if (mem_err !== 1'b0 || err_addr !== 32'h21) begin
            errors++; $display("FAIL err_clr got err=%b addr=%h exp err=0 addr=00000021", mem_err, err_addr);
        end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bad_f3_rdata got=%h exp=%h", got, exp); end
        idle();
        checks++;
        if (mem_err !== 1'b1 || err_addr !== 32'h10 || ld_count !== ld_exp || st_count !== st_exp) begin
            errors++;
            $display("FAIL bad_f3_err got err=%b addr=%h ld=%0d st=%0d exp err=1 addr=00000010 ld=%0d st=%0d",
                     mem_err, err_addr, ld_count, st_count, ld_exp, st_exp);
        end
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0);
        idle();
    endtask

    task automatic test_rw_same();
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'h0); st_exp++;
        exp_q.push_back(32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h12345678); st_exp++;
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rw_old_data got=%h exp=%h", got, exp); end
        exp_q.push_back(32'h12345678);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0); ld_exp++;
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rw_new_data got=%h exp=%h", got, exp); end
        idle();
        checks++;
        if (ld_count !== ld_exp || st_count !== st_exp) begin
            errors++; $display("FAIL rw_counts got ld=%0d st=%0d exp ld=%0d st=%0d", ld_count, st_count, ld_exp, st_exp);
        end
    endtask

    task automatic test_random();
        logic [2:0]  ld_f3_t [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] wd;
        logic [31:0] a;
        logic [2:0]  f3;
        int          off;
        int          sz;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100 + 32'(4 * w), wd); st_exp++;
            for (int b = 0; b < 4; b++) model_b[4 * w + b] = wd[8 * b +: 8];
        end
        for (int n = 0; n < 200; n++) begin
            off = $urandom_range(0, 63);
            if ($urandom_range(0, 2) == 0) begin
                f3 = 3'($urandom_range(0, 2));
                sz = 1 << f3[1:0];
                off = off - (off % sz);
                wd = $urandom;
                a = 32'h100 + 32'(off);
                drive(1'b1, 1'b0, 1'b0, f3, a, wd); st_exp++;
                for (int b = 0; b < sz; b++) model_b[off + b] = wd[8 * b +: 8];
            end else begin
                f3 = ld_f3_t[$urandom_range(0, 4)];
                sz = 1 << f3[1:0];
                off = off - (off % sz);
                a = 32'h100 + 32'(off);
                case (f3)
                    3'b000:  exp = {{24{model_b[off][7]}}, model_b[off]};
                    3'b100:  exp = {24'h0, model_b[off]};
                    3'b001:  exp = {{16{model_b[off + 1][7]}}, model_b[off + 1], model_b[off]};
                    3'b101:  exp = {16'h0, model_b[off + 1], model_b[off]};
                    default: exp = {model_b[off + 3], model_b[off + 2], model_b[off + 1], model_b[off]};
                endcase
                exp_q.push_back(exp);
                drive(1'b0, 1'b1, 1'b0, f3, a, 32'h0); ld_exp++;
                got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL rand_load f3=%b addr=%h got=%h exp=%h", f3, a, got, exp);
                end
            end
        end
        idle();
        checks++;
        if (ld_count !== ld_exp || st_count !== st_exp || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_counts got ld=%0d st=%0d err=%b exp ld=%0d st=%0d err=0",
                     ld_count, st_count, mem_err, ld_exp, st_exp);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 65535; i++) drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'(i));
        idle();
        checks++;
        if (st_count !== 16'hFFFF) begin errors++; $display("FAIL st_full got=%h exp=ffff", st_count); end
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'hCAFEF00D);
        idle();
        checks++;
        if (st_count !== 16'h0) begin errors++; $display("FAIL st_wrap got=%h exp=0000", st_count); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h13, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        idle();
        checks++;
        if (mem_err !== 1'b1 || ld_count !== 16'd1) begin
            errors++; $display("FAIL pre_reset got err=%b ld=%0d exp err=1 ld=1", mem_err, ld_count);
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h30, 32'h0BADBEEF);
        idle();
        rst = 1'b0;
        checks++;
        if ({mem_err, err_addr, ld_count, st_count} !== 65'h0) begin
            errors++;
            $display("FAIL mid_reset_regs got err=%b addr=%h ld=%h st=%h exp all 0", mem_err, err_addr, ld_count, st_count);
        end
        exp_q.push_back(32'hCAFEF00D);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        got = bus.ram_rdata; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_store_dropped got=%h exp=%h", got, exp); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        bus.ram_we = 1'b0;
        bus.ram_re = 1'b0;
        bus.ram_func3 = 3'b000;
        bus.ram_addr = 32'h0;
        bus.ram_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_rw_same();
        test_random();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
